// File: rtl/lifo_arbiter_pkg.sv
// lifo_arbiter_pkg
//   Shared types and default sizing for the LIFO arbiter slice.
//   - state_e : transaction FSM states (IDLE -> EXEC -> RESP -> IDLE)
//   - op_e    : operation latched for the current winner
//   - DEF_*   : default DATA_W / DEPTH / N_REQ values used by the top
package lifo_arbiter_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 8;
  localparam int DEF_N_REQ  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic {
    OP_PUSH = 1'b0,
    OP_POP  = 1'b1
  } op_e;

endpackage

// File: rtl/lifo_core.sv
// lifo_core
//   Stack storage with pointer/count and status flags.
//   Ports:
//     clock, reset_n      : clock, asynchronous active-low reset
//     push_stb, pop_stb   : single-cycle operation strobes
//     wdata [DATA_W]      : data written on push_stb
//     top_data [DATA_W]   : current top-of-stack entry (meaningful when !empty)
//     count               : number of valid entries, 0..DEPTH
//     full, empty         : combinational decode of count
//   A push while full or a pop while empty is ignored. Push wins if both
//   strobes are ever asserted together.
module lifo_core #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push_stb,
  input  logic                     pop_stb,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        top_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Storage is deliberately left unreset; count==0 makes its contents moot.
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;
  logic [AW-1:0] top_idx;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

  assign do_push = push_stb && !full;
  assign do_pop  = pop_stb && !empty && !push_stb;

  always_comb begin
    count_d = count_q;
    if (do_push) begin
      count_d = count_q + CW'(1);
    end else if (do_pop) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Write slot is the current count; when full the low bits wrap to 0, but
  // do_push is blocked then, so no overwrite happens.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem_q[count_q[AW-1:0]] <= wdata;
    end
  end

  // Top entry sits one below the write slot. At count==DEPTH the low bits
  // are zero and the subtraction wraps to DEPTH-1, which is correct.
  assign top_idx  = count_q[AW-1:0] - AW'(1);
  assign top_data = mem_q[top_idx];

endmodule

// File: rtl/lifo_arbiter.sv
// lifo_arbiter
//   Round-robin arbiter in front of a shared LIFO stack. One transaction at
//   a time: IDLE (arbitrate) -> EXEC (grant, access stack) -> RESP (done).
//   Ports:
//     clock, reset_n        : clock, asynchronous active-low reset
//     push_req, pop_req     : per-requester requests (push wins if both)
//     push_data             : requester i data at [i*DATA_W +: DATA_W]
//     gnt                   : one-hot grant, high during EXEC only
//     done                  : one-hot completion pulse, high during RESP only
//     err                   : push-while-full / pop-while-empty, valid with done
//     rdata                 : pop result, valid with done (0 on error)
//     full, empty, count    : stack status
//     err_count (optional)  : saturating count of error completions, present
//                             only when LIFO_ARBITER_STATS_EN is defined
module lifo_arbiter
  import lifo_arbiter_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int N_REQ  = DEF_N_REQ
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [N_REQ-1:0]         push_req,
  input  logic [N_REQ-1:0]         pop_req,
  input  logic [N_REQ*DATA_W-1:0]  push_data,
  output logic [N_REQ-1:0]         gnt,
  output logic [N_REQ-1:0]         done,
  output logic                     err,
  output logic [DATA_W-1:0]        rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
`ifdef LIFO_ARBITER_STATS_EN
  ,
  output logic [15:0]              err_count
`endif
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   winner_q, winner_d;
  logic [IDX_W-1:0]   last_q, last_d;
  op_e                op_q, op_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               err_q, err_d;

  logic [N_REQ-1:0]   eligible;
  logic               found;
  logic [IDX_W-1:0]   pick;
  logic [IDX_W-1:0]   cand;

  logic               push_stb, pop_stb;
  logic [DATA_W-1:0]  wdata;
  logic [DATA_W-1:0]  top_data;
  logic               core_full, core_empty;

  lifo_core #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_core (
    .clock    (clock),
    .reset_n  (reset_n),
    .push_stb (push_stb),
    .pop_stb  (pop_stb),
    .wdata    (wdata),
    .top_data (top_data),
    .count    (count),
    .full     (core_full),
    .empty    (core_empty)
  );

  assign full  = core_full;
  assign empty = core_empty;

  // Round-robin search: walk indices starting just after last winner,
  // wrapping at N_REQ-1, and take the first eligible one.
  assign eligible = push_req | pop_req;

  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = last_q;
    for (int off = 0; off < N_REQ; off++) begin
      cand = (cand == IDX_W'(N_REQ - 1)) ? '0 : cand + IDX_W'(1);
      if (!found && eligible[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // ---------------- state register ----------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = found ? EXEC : IDLE;
      EXEC:    state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- transaction / response registers ----------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      winner_q <= '0;
      last_q   <= IDX_W'(N_REQ - 1);
      op_q     <= OP_PUSH;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      winner_q <= winner_d;
      last_q   <= last_d;
      op_q     <= op_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    winner_d = winner_q;
    last_d   = last_q;
    op_d     = op_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          winner_d = pick;
          op_d     = push_req[pick] ? OP_PUSH : OP_POP;
        end
      end
      EXEC: begin
        if (op_q == OP_PUSH) begin
          err_d   = core_full;
          rdata_d = '0;
        end else begin
          err_d   = core_empty;
          rdata_d = core_empty ? '0 : top_data;
        end
      end
      RESP: begin
        last_d = winner_q;
      end
      default: ;
    endcase
  end

  // ---------------- outputs ----------------
  always_comb begin
    gnt      = '0;
    done     = '0;
    err      = 1'b0;
    push_stb = 1'b0;
    pop_stb  = 1'b0;
    case (state_q)
      EXEC: begin
        gnt      = N_REQ'(1) << winner_q;
        push_stb = (op_q == OP_PUSH);
        pop_stb  = (op_q == OP_POP);
      end
      RESP: begin
        done = N_REQ'(1) << winner_q;
        err  = err_q;
      end
      default: ;
    endcase
  end

  // Winner's data is taken live in EXEC, not at arbitration time.
  assign wdata = push_data[int'(winner_q)*DATA_W +: DATA_W];
  assign rdata = rdata_q;

`ifdef LIFO_ARBITER_STATS_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if ((state_q == RESP) && err_q && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_count = err_cnt_q;
`endif

endmodule

// File: doc/lifo_arbiter.md
LIFO_ARBITER -- requirements
Module: lifo_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning data width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 8, meaning number of stack entries (power of 2, at least 2).
REQ-003 The block SHALL have parameter N_REQ, default 4, meaning number of requesters.
REQ-004 The block SHALL have port clock, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-005 The block SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have port push_req, input, N_REQ, per-requester push request.
REQ-007 The block SHALL have port pop_req, input, N_REQ, per-requester pop request.
REQ-008 The block SHALL have port push_data, input, N_REQ*DATA_W, per-requester write data, with requester i at bits [i*DATA_W +: DATA_W].
REQ-009 The block SHALL have port gnt, output, N_REQ, one-hot grant to the requester being served.
REQ-010 The block SHALL have port done, output, N_REQ, one-cycle completion pulse to the served requester.
REQ-011 The block SHALL have port err, output, 1, error flag, valid only while any done bit is 1.
REQ-012 The block SHALL have port rdata, output, DATA_W, pop result, valid only while done is 1.
REQ-013 The block SHALL have ports full (output, 1), empty (output, 1) and count (output, $clog2(DEPTH)+1), giving the stack status.

Function
REQ-014 The block SHALL use FSM states IDLE -> EXEC -> RESP -> IDLE and process one transaction at a time.
REQ-015 In IDLE, requester i SHALL be eligible if push_req[i] or pop_req[i] is 1; with no eligible requester the FSM SHALL stay in IDLE.
REQ-016 Arbitration SHALL be round-robin: search starts at index (last_winner+1) mod N_REQ; the winner and its operation SHALL be registered and the FSM SHALL go to EXEC.
REQ-017 If push_req[i] and pop_req[i] are both 1, the operation SHALL be push.
REQ-018 In EXEC, gnt SHALL be one-hot for the winner (all zero in the other states), and a push SHALL write push_data of the winner, sampled in this cycle, at the stack pointer.
REQ-019 In EXEC, a pop SHALL load the top entry into the rdata register and decrement the pointer.
REQ-020 A push while full SHALL leave the stack unchanged and set err=1.
REQ-021 A pop while empty SHALL leave the stack unchanged, set rdata=0 and set err=1.
REQ-022 In RESP, done[winner] SHALL be 1 for exactly one cycle with err and rdata valid; last_winner SHALL update; the FSM SHALL return to IDLE.
REQ-023 Latency SHALL be fixed: request sampled at edge k, gnt high in cycle k+1, done high in cycle k+2, next arbitration at edge k+3.
REQ-024 Peak throughput SHALL be one transaction per 3 cycles.
REQ-025 Requester drops during EXEC or RESP SHALL NOT abort the transaction.
REQ-026 A requester SHALL hold its request until done; a request still high in IDLE after done SHALL be treated as a new transaction.
REQ-027 full SHALL equal (count==DEPTH) and empty SHALL equal (count==0), both combinational from count.
REQ-028 The stack SHALL be a true LIFO: after pushes A, B, C, pops SHALL return C, B, A.

Reset
REQ-029 While reset_n is 0: state=IDLE, count=0, empty=1, full=0, gnt=0, done=0, err=0, rdata=0, last_winner=N_REQ-1 (so requester 0 has first priority).
REQ-030 Reset asserted mid-transaction SHALL abort it with no done pulse, and stack contents SHALL be treated as discarded.
REQ-031 Storage array contents need not be reset.

Configuration
REQ-032 With macro LIFO_ARBITER_STATS_EN defined, the block SHALL add output err_count, 16 bits, counting err=1 completions, saturating at 16'hFFFF, reset to 0.
REQ-033 Without LIFO_ARBITER_STATS_EN, err_count and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-034 Package lifo_arbiter_pkg SHALL hold the FSM state enum (IDLE, EXEC, RESP), the op enum (OP_PUSH, OP_POP) and the default DATA_W/DEPTH/N_REQ constants.
REQ-035 Sub-module lifo_core SHALL hold storage, stack pointer, count, full and empty, with single-cycle push/pop strobes.
REQ-036 lifo_arbiter SHALL contain only arbitration, FSM and response registers.

Verification
REQ-037 Reset, then push_req[0] with data 100, 150, 200 in turn, then pop_req[0] three times -> rdata 200, 150, 100 with err=0; then empty=1 and count=0.
REQ-038 push_req=4'b1111 held, data 10/20/30/40 for requesters 0..3 -> grants in order 0,1,2,3 each 3 cycles apart; count=4; then four pops -> 40, 30, 20, 10.
REQ-039 DEPTH=8: nine pushes -> ninth done has err=1, count stays 8, full=1; a pop on empty -> err=1, rdata=0.
REQ-040 push_req[2] and pop_req[2] high together with data 55 -> push performed, count increments, err=0.
REQ-041 Reset_n pulsed low during EXEC of a push -> no done pulse, count=0, empty=1, gnt=0; next request is granted to requester 0 first.
REQ-042 With LIFO_ARBITER_STATS_EN defined, 3 error completions -> err_count=3; without the macro, the build has no err_count port.
